dbg_host: RTL

Host-side initiator for the UART debugger memory-access protocol. Accepts word-level requests (read byte, write byte, read status) on a simple request port and serialises them into the command-byte stream: `i`, `a`+addr_hi+addr_lo, `w`+data, `r`. It collects the one-byte responses and sits between a test/boot controller and a byte UART transmitter/receiver pair. A shadow copy of the target's auto-incrementing address suppresses redundant `a` sequences.

---
 rtl/dbg_pkg.sv | 42 ++++
 rtl/dbg_host_timer.sv | 33 +++
 rtl/dbg_host.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared debugger definitions: command bytes, request encodings and FSM states.
// Used by both the host initiator and the target-side debugger.
package dbg_pkg;

  localparam logic [7:0] DBG_CMD_A = 8'h61;
  localparam logic [7:0] DBG_CMD_I = 8'h69;
  localparam logic [7:0] DBG_CMD_W = 8'h77;
  localparam logic [7:0] DBG_CMD_R = 8'h72;

  typedef enum logic [1:0] {
    CMD_STATUS = 2'd0,
    CMD_READ   = 2'd1,
    CMD_WRITE  = 2'd2,
    CMD_RSVD   = 2'd3
  } dbg_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_OP_CMD,
    ST_WDATA,
    ST_WAIT_RSP
  } dbg_state_e;

  // The reserved encoding behaves exactly like a status request.
  function automatic logic is_status(input dbg_cmd_e c);
    return (c == CMD_STATUS) || (c == CMD_RSVD);
  endfunction

  function automatic logic [7:0] op_byte(input dbg_cmd_e c);
    logic [7:0] b;
    case (c)
      CMD_READ:  b = DBG_CMD_R;
      CMD_WRITE: b = DBG_CMD_W;
      default:   b = DBG_CMD_I;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dbg_host_timer.sv
// Response timeout: loads TIMEOUT-1 on start, counts down, flags expire at zero.
module dbg_host_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic          running;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= LOAD;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - ONE;
    end
  end

  assign expire = running && (cnt == '0);

endmodule

// File: rtl/dbg_host.sv
// Host-side debugger initiator: serialises read/write/status requests into the
// UART command-byte stream and collects the single-byte response.
module dbg_host
  import dbg_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  cmd,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        timeout,
  output logic [7:0]  txd,
  output logic        txv,
  input  logic        txrdy,
  input  logic [7:0]  rxd,
  input  logic        rxv
);

  dbg_state_e state, next_state;
  dbg_cmd_e   cmd_in, cmd_q;
  logic [15:0] addr_q, sh_addr;
  logic [7:0]  wdata_q;
  logic        sh_valid;
  logic        hs, addr_hit, timer_start, expire;

  assign cmd_in   = dbg_cmd_e'(cmd);
  assign hs       = txv && txrdy;
  assign addr_hit = sh_valid && (addr == sh_addr);
  assign timer_start = (state == ST_OP_CMD) && hs && (cmd_q != CMD_WRITE);

  dbg_host_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (timer_start),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (req) next_state = (is_status(cmd_in) || addr_hit) ? ST_OP_CMD : ST_ADDR_CMD;
      ST_ADDR_CMD: if (hs) next_state = ST_ADDR_HI;
      ST_ADDR_HI:  if (hs) next_state = ST_ADDR_LO;
      ST_ADDR_LO:  if (hs) next_state = ST_OP_CMD;
      ST_OP_CMD:   if (hs) next_state = (cmd_q == CMD_WRITE) ? ST_WDATA : ST_WAIT_RSP;
      ST_WDATA:    if (hs) next_state = ST_IDLE;
      ST_WAIT_RSP: if (rxv || expire) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Transmit bytes come straight from the state and latched request, so they
  // stay stable for as long as the transmitter stalls.
  always_comb begin
    busy = (state != ST_IDLE);
    txv  = 1'b0;
    txd  = 8'h00;
    case (state)
      ST_ADDR_CMD: begin txv = 1'b1; txd = DBG_CMD_A;     end
      ST_ADDR_HI:  begin txv = 1'b1; txd = addr_q[15:8];  end
      ST_ADDR_LO:  begin txv = 1'b1; txd = addr_q[7:0];   end
      ST_OP_CMD:   begin txv = 1'b1; txd = op_byte(cmd_q); end
      ST_WDATA:    begin txv = 1'b1; txd = wdata_q;       end
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= CMD_STATUS;
      addr_q   <= '0;
      wdata_q  <= '0;
      sh_addr  <= '0;
      sh_valid <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      rdata    <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (state == ST_IDLE && req) begin
        cmd_q   <= cmd_in;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == ST_WDATA && hs) begin
        done     <= 1'b1;
        sh_addr  <= addr_q + 16'd1;
        sh_valid <= 1'b1;
      end
      // A response arriving on the expiry cycle still counts as a response.
      if (state == ST_WAIT_RSP) begin
        if (rxv) begin
          done  <= 1'b1;
          rdata <= rxd;
          if (!is_status(cmd_q)) begin
            sh_addr  <= addr_q + 16'd1;
            sh_valid <= 1'b1;
          end
        end else if (expire) begin
          done     <= 1'b1;
          timeout  <= 1'b1;
          rdata    <= 8'h00;
          sh_valid <= 1'b0;
        end
      end
    end
  end

endmodule
